// File: rtl/activation_store_arbiter.sv
// Activation store arbiter.
// Shares one two-port activation store between the activation loader (writes)
// and two PE read lanes. Grants are combinational. Read data comes back one
// cycle after grant, routed by a small per-lane response tag.
module activation_store_arbiter #(
  parameter int value_width   = 16,
  parameter int address_width = 10,
  parameter int wr_burst_max  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [address_width-1:0] wr_addr,
  input  logic [value_width-1:0]   wr_data,
  input  logic                     rd0_valid,
  output logic                     rd0_ready,
  input  logic [address_width-1:0] rd0_addr,
  output logic                     rd0_rvalid,
  output logic [value_width-1:0]   rd0_rdata,
  input  logic                     rd1_valid,
  output logic                     rd1_ready,
  input  logic [address_width-1:0] rd1_addr,
  output logic                     rd1_rvalid,
  output logic [value_width-1:0]   rd1_rdata,
  output logic                     st_wr_en,
  output logic [address_width-1:0] st_address1,
  output logic [address_width-1:0] st_address2,
  output logic [value_width-1:0]   st_write_value,
  input  logic [value_width-1:0]   st_read_val1,
  input  logic [value_width-1:0]   st_read_val2
);

  localparam int CntWidth = $clog2(wr_burst_max + 1);
  localparam logic [CntWidth-1:0] BurstMax = CntWidth'(wr_burst_max);

  typedef enum logic {
    RrRd0 = 1'b0,
    RrRd1 = 1'b1
  } rrSel_e;

  typedef enum logic {
    PortOne = 1'b0,
    PortTwo = 1'b1
  } storePort_e;

  logic [CntWidth-1:0] burstCnt_q, burstCnt_d;
  rrSel_e              rrPtr_q, rrPtr_d;
  logic                tag0Valid_q, tag1Valid_q;
  storePort_e          tag0Port_q, tag1Port_q;

  logic       forceRd;
  logic       wgrant;
  logic       elig0, elig1;
  logic       grant0, grant1;
  storePort_e port0, port1;
  logic       rrFlip;
  logic       readerDenied;

  // Decide who owns each store port this cycle: writer first unless readers
  // have been starved for a full burst, then readers by hazard and fairness.
  always_comb begin
    forceRd = (burstCnt_q == BurstMax) & rd0_valid & rd1_valid;
    wgrant  = ~reset & wr_valid & ~forceRd;
    elig0   = ~reset & rd0_valid & ~(wgrant & (rd0_addr == wr_addr));
    elig1   = ~reset & rd1_valid & ~(wgrant & (rd1_addr == wr_addr));
    grant0  = 1'b0;
    grant1  = 1'b0;
    port0   = PortOne;
    port1   = PortOne;
    rrFlip  = 1'b0;
    if (wgrant) begin
      if (elig0 && elig1) begin
        rrFlip = 1'b1;
        if (rrPtr_q == RrRd0) begin
          grant0 = 1'b1;
          port0  = PortTwo;
        end else begin
          grant1 = 1'b1;
          port1  = PortTwo;
        end
      end else if (elig0) begin
        grant0 = 1'b1;
        port0  = PortTwo;
      end else if (elig1) begin
        grant1 = 1'b1;
        port1  = PortTwo;
      end
    end else begin
      if (elig0 && elig1) begin
        grant0 = 1'b1;
        port0  = PortOne;
        grant1 = 1'b1;
        port1  = PortTwo;
      end else if (elig0) begin
        grant0 = 1'b1;
        port0  = PortTwo;
      end else if (elig1) begin
        grant1 = 1'b1;
        port1  = PortTwo;
      end
    end
  end

  // Drive the store ports from the grant decision; idle ports read as zero.
  always_comb begin
    wr_ready       = wgrant;
    rd0_ready      = grant0;
    rd1_ready      = grant1;
    st_wr_en       = wgrant;
    st_write_value = wgrant ? wr_data : '0;
    st_address1    = '0;
    st_address2    = '0;
    if (wgrant) begin
      st_address1 = wr_addr;
    end else if (grant0 && (port0 == PortOne)) begin
      st_address1 = rd0_addr;
    end else if (grant1 && (port1 == PortOne)) begin
      st_address1 = rd1_addr;
    end
    if (grant0 && (port0 == PortTwo)) begin
      st_address2 = rd0_addr;
    end else if (grant1 && (port1 == PortTwo)) begin
      st_address2 = rd1_addr;
    end
  end

  // Count consecutive write grants that left a reader waiting, and advance
  // the round-robin pointer only when it actually broke a tie.
  always_comb begin
    readerDenied = (rd0_valid & ~grant0) | (rd1_valid & ~grant1);
    burstCnt_d   = '0;
    if (wgrant && readerDenied) begin
      burstCnt_d = (burstCnt_q == BurstMax) ? burstCnt_q : burstCnt_q + CntWidth'(1);
    end
    rrPtr_d = rrPtr_q;
    if (rrFlip) begin
      rrPtr_d = (rrPtr_q == RrRd0) ? RrRd1 : RrRd0;
    end
  end

  // Arbitration state and response tags; reset drops any response in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burstCnt_q  <= '0;
      rrPtr_q     <= RrRd0;
      tag0Valid_q <= 1'b0;
      tag0Port_q  <= PortOne;
      tag1Valid_q <= 1'b0;
      tag1Port_q  <= PortOne;
    end else begin
      burstCnt_q  <= burstCnt_d;
      rrPtr_q     <= rrPtr_d;
      tag0Valid_q <= grant0;
      tag0Port_q  <= port0;
      tag1Valid_q <= grant1;
      tag1Port_q  <= port1;
    end
  end

  // Steer the store's registered read data back to the lane that asked for it.
  always_comb begin
    rd0_rvalid = tag0Valid_q;
    rd1_rvalid = tag1Valid_q;
    rd0_rdata  = '0;
    rd1_rdata  = '0;
    if (tag0Valid_q) begin
      rd0_rdata = (tag0Port_q == PortTwo) ? st_read_val2 : st_read_val1;
    end
    if (tag1Valid_q) begin
      rd1_rdata = (tag1Port_q == PortTwo) ? st_read_val2 : st_read_val1;
    end
  end

endmodule
